// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter slice.
package mem_pkg;

  localparam int DEF_DATA_WIDTH    = 32;
  localparam int DEF_ADDRESS_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RELEASE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side handshake bundle for the two-port memory arbiter.
interface mem_arbiter_if
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH
);

  logic                     req0_valid;
  logic                     req0_we;
  logic [ADDRESS_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]    req0_wdata;
  logic                     req0_done;
  logic [DATA_WIDTH-1:0]    req0_rdata;

  logic                     req1_valid;
  logic                     req1_we;
  logic [ADDRESS_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]    req1_wdata;
  logic                     req1_done;
  logic [DATA_WIDTH-1:0]    req1_rdata;

  // Requesters drive the request fields and observe completion.
  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata,
    input  req0_done, req0_rdata,
    output req1_valid, req1_we, req1_addr, req1_wdata,
    input  req1_done, req1_rdata
  );

  // The arbiter consumes requests and reports completion.
  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata,
    output req0_done, req0_rdata,
    input  req1_valid, req1_we, req1_addr, req1_wdata,
    output req1_done, req1_rdata
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on contention the pointer decides, otherwise
// whichever requester is valid wins.
module rr_arbiter2 (
  input  logic valid0,
  input  logic valid1,
  input  logic prio,
  output logic grant,
  output logic any_grant
);

  // Grant index selection from the current valids and priority pointer.
  always_comb begin
    grant = 1'b0;
    if (valid0 && valid1) grant = prio;
    else if (valid1)      grant = 1'b1;
  end

  assign any_grant = valid0 | valid1;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: one transaction at a time over a shared
// tristate data bus, with round-robin grant and an access timeout.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int TIMEOUT       = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_arbiter_if.slave             req,
  output logic                     err,
  output logic                     sel,
  output logic                     w_en,
  output logic [ADDRESS_WIDTH-1:0] address_bus,
  inout  wire  [DATA_WIDTH-1:0]    data_bus,
  input  logic                     mem_ready
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                  state, state_d;
  logic                    prio;
  logic                    grant, any_grant;
  logic                    grant_q;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    done0, done1;
  logic [DATA_WIDTH-1:0]   rdata0, rdata1;
  logic                    do_grant, do_finish, do_abort;
  logic                    gnt_we;
  logic [ADDRESS_WIDTH-1:0] gnt_addr;
  logic [DATA_WIDTH-1:0]   gnt_wdata;

  rr_arbiter2 u_rr (
    .valid0    (req.req0_valid),
    .valid1    (req.req1_valid),
    .prio      (prio),
    .grant     (grant),
    .any_grant (any_grant)
  );

  assign gnt_we    = grant ? req.req1_we    : req.req0_we;
  assign gnt_addr  = grant ? req.req1_addr  : req.req0_addr;
  assign gnt_wdata = grant ? req.req1_wdata : req.req0_wdata;

  // Only the arbiter drives the bus, and only during a write access.
  assign data_bus = (sel && w_en) ? wdata_q : {DATA_WIDTH{1'bz}};

  assign req.req0_done  = done0;
  assign req.req1_done  = done1;
  assign req.req0_rdata = rdata0;
  assign req.req1_rdata = rdata1;

  // Next-state decode; the action strobes steer the registered outputs.
  always_comb begin
    state_d   = state;
    do_grant  = 1'b0;
    do_finish = 1'b0;
    do_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (any_grant) begin
          do_grant = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          do_finish = 1'b1;
          state_d   = RELEASE;
        end else if (cnt == CNT_LAST) begin
          do_abort = 1'b1;
          state_d  = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Registered bus controls, grant latch, timeout counter and completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel         <= 1'b0;
      w_en        <= 1'b0;
      address_bus <= '0;
      wdata_q     <= '0;
      grant_q     <= 1'b0;
      prio        <= 1'b0;
      cnt         <= '0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err         <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
    end else begin
      done0 <= (do_finish || do_abort) && !grant_q;
      done1 <= (do_finish || do_abort) &&  grant_q;
      err   <= do_abort;
      if (do_grant) begin
        sel         <= 1'b1;
        w_en        <= gnt_we;
        address_bus <= gnt_addr;
        wdata_q     <= gnt_wdata;
        grant_q     <= grant;
        prio        <= ~grant;
        cnt         <= '0;
      end else if (do_finish || do_abort) begin
        sel  <= 1'b0;
        w_en <= 1'b0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 1'b1;
      end
      // w_en still holds the latched direction on the completing edge.
      if (do_finish && !w_en) begin
        if (grant_q) rdata1 <= data_bus;
        else         rdata0 <= data_bus;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of the memory data bus and requester data.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 8, width of the memory address bus and requester addresses.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum cycles spent waiting for mem_ready before abort.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports reqN_valid  input  1  access request, held until reqN_done (N = 0, 1).
REQ-007 SHALL have ports reqN_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports reqN_addr  input  ADDRESS_WIDTH  target address.
REQ-009 SHALL have ports reqN_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports reqN_done  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports reqN_rdata  output  DATA_WIDTH  read data, valid while reqN_done = 1.
REQ-012 SHALL have port err  output  1  one-cycle pulse on timeout abort.
REQ-013 SHALL have port sel  output  1  memory select.
REQ-014 SHALL have port w_en  output  1  memory write enable.
REQ-015 SHALL have port address_bus  output  ADDRESS_WIDTH  memory address.
REQ-016 SHALL have port data_bus  inout  DATA_WIDTH  shared memory data bus.
REQ-017 SHALL have port mem_ready  input  1  memory completion indication.

Function
REQ-018 SHALL implement FSM IDLE -> ACCESS -> RELEASE -> IDLE.
REQ-019 IDLE: at an edge with any reqN_valid = 1, SHALL latch the grant index, we, addr and wdata, and enter ACCESS; sel/w_en/address_bus SHALL be registered and asserted from that edge.
REQ-020 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; the priority pointer after reset SHALL favour requester 0.
REQ-021 ACCESS: sel = 1, w_en = latched we, address_bus = latched addr, held constant until exit.
REQ-022 SHALL drive data_bus with latched wdata only while sel = 1 and w_en = 1; otherwise high-Z.
REQ-023 ACCESS: at an edge with mem_ready = 1, SHALL capture data_bus into the granted reqN_rdata (reads only), deassert sel and w_en, and enter RELEASE.
REQ-024 RELEASE: SHALL pulse the granted reqN_done for exactly one cycle with sel = 0, then return to IDLE; sel SHALL therefore stay low for at least one full cycle between transactions.
REQ-025 SHALL count cycles in ACCESS; on reaching TIMEOUT without mem_ready, SHALL deassert sel, pulse err and reqN_done together in RELEASE, and leave reqN_rdata unchanged.
REQ-026 A requester dropping reqN_valid during ACCESS SHALL NOT abort the transaction; done still pulses.
REQ-027 Requests arriving while not IDLE SHALL wait; no request SHALL be lost while held.
REQ-028 reqN_rdata SHALL hold its last value between reads.

Reset
REQ-029 On rst_n = 0, SHALL immediately set state IDLE, sel = 0, w_en = 0, address_bus = 0, data_bus high-Z, reqN_done = 0, reqN_rdata = 0, err = 0, timeout counter = 0, priority pointer = requester 0.
REQ-030 Reset during ACCESS SHALL abandon the transaction without a done pulse.

Structure
REQ-031 Shared package mem_pkg SHALL hold the FSM state type and default DATA_WIDTH/ADDRESS_WIDTH constants.
REQ-032 Round-robin selection SHALL live in sub-module rr_arbiter2 (inputs: two valids, priority pointer; output: grant index, any_grant).

Verification (memory instance LATENCY = 3)
REQ-033 req0 write addr 0x05 data 0xDEADBEEF, then req0 read 0x05 -> req0_done pulses twice, req0_rdata = 0xDEADBEEF on second pulse.
REQ-034 req0 and req1 valid on same edge after reset (writes to 0x10/0x11) -> req0 served first, then req1; sel low for at least 1 cycle between them.
REQ-035 Both requesters continuously valid for 8 transactions -> grants alternate 0,1,0,1,...; each done count = 4.
REQ-036 mem_ready tied 0, TIMEOUT = 8 -> sel high 8 cycles, then err and req0_done pulse together, state returns to IDLE.
REQ-037 rst_n asserted mid-ACCESS -> sel, w_en drop in same cycle, data_bus high-Z, no done pulse; next request after release completes normally.
